if_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the PC generator.
- Consumes the 65-bit PC bus, issues requests on an SRAM-like instruction port (req / addr_ok / data_ok), and tracks up to DEPTH outstanding fetches.
- Buffers returned words in order and presents {excepttype, pc, inst} to decode with a valid/ready handshake.
- Handles pipeline flush by dropping queued entries and discarding responses that are still in flight.

---
 rtl/if_fetch.sv | 221 ++++++++++++++++++++++
 tb/tb_if_fetch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage sitting behind the PC generator.
//
// Takes {excepttype, ce, pc} from the PC stage and issues single-beat reads on
// an SRAM-like port (req / addr_ok / data_ok). It tracks up to DEPTH fetches
// in a ring, where each fetch is either in flight or buffered. Words come back
// in request order and are handed to decode as {excepttype, pc, inst} with a
// valid/ready handshake.
//
// Three pointers walk the ring:
//   wr   - next slot to allocate (advances on accept)
//   fill - oldest slot still waiting for its response word
//   rd   - queue head offered to decode
// On a flush the ring is emptied at once. Responses still owed by the memory
// are counted in discard_cnt and swallowed as they arrive.
//
// Optional build macro IF_ADEL_CHECK_EN: a misaligned pc (pc[1:0] != 0) is not
// sent to memory. It takes a slot that is complete on allocation, with
// excepttype[14] (AdEL on fetch) set and inst = 0, and it stays in program
// order behind earlier fetches.

module if_fetch #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [64:0] pc_to_ic_bus,
  output logic        pc_ready,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [95:0] ic_to_id_bus
);

  // Pointers and counters carry one extra bit so that full and empty differ.
  typedef logic [PTR_W:0]   ptr_t;
  typedef logic [PTR_W-1:0] idx_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE     = ptr_t'(1);
  localparam ptr_t ZERO    = ptr_t'(0);

  // Unpacked view of the PC-stage bus.
  logic [31:0] exc_in;
  logic        ce_in;
  logic [31:0] pc_in;

  assign exc_in = pc_to_ic_bus[64:33];
  assign ce_in  = pc_to_ic_bus[32];
  assign pc_in  = pc_to_ic_bus[31:0];

  // Ring state.
  ptr_t             wr_ptr;
  ptr_t             fill_ptr;
  ptr_t             rd_ptr;
  ptr_t             discard_cnt;
  logic [DEPTH-1:0] done;
  logic [31:0]      ent_exc  [DEPTH];
  logic [31:0]      ent_pc   [DEPTH];
  logic [31:0]      ent_inst [DEPTH];

  // Derived control.
  ptr_t occupancy;
  logic has_space;
  logic misaligned;
  logic req_raw;
  logic accept;
  logic adel_alloc;
  logic alloc;
  ptr_t fill_eff;
  ptr_t outstanding;
  logic fill_en;
  logic pop;
  ptr_t discard_flush;
  idx_t wr_idx;
  idx_t fill_idx;
  idx_t rd_idx;

  assign wr_idx   = wr_ptr[PTR_W-1:0];
  assign fill_idx = fill_eff[PTR_W-1:0];
  assign rd_idx   = rd_ptr[PTR_W-1:0];

  // Space is decided from registered pointers only, so a pop in this cycle
  // frees its slot one cycle later and no comb path runs from id_ready to req.
  assign occupancy = wr_ptr - rd_ptr;
  assign has_space = occupancy < DEPTH_P;

`ifdef IF_ADEL_CHECK_EN
  assign misaligned = |pc_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // req_raw ignores flush. The flush bookkeeping needs to know whether the
  // memory may have taken a request in the flush cycle.
  assign req_raw        = ce_in & has_space & ~misaligned;
  assign inst_sram_req  = req_raw & ~flush & ~rst;
  assign inst_sram_addr = pc_in;
  assign accept         = inst_sram_req & inst_sram_addr_ok;

  // A misaligned pc takes a slot without a memory transaction.
  assign adel_alloc = ce_in & has_space & misaligned & ~flush & ~rst;
  assign alloc      = accept | adel_alloc;
  assign pc_ready   = alloc;

`ifdef IF_ADEL_CHECK_EN
  // Slots that complete on allocation can sit between fill and wr. Step
  // fill past them so a response always lands in the oldest slot still owed
  // a word, and count only the slots that are truly in flight.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and gives every output a
    // default first, so no path can leave a value held (which infers a latch).
    ptr_t scan;
    fill_eff    = fill_ptr;
    outstanding = ZERO;
    scan        = ZERO;
    for (int k = 0; k < DEPTH; k++) begin
      if (fill_eff != wr_ptr && done[fill_eff[PTR_W-1:0]]) begin
        fill_eff = fill_eff + ONE;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      scan = fill_ptr + ptr_t'(k);
      if (ptr_t'(k) < (wr_ptr - fill_ptr) && !done[scan[PTR_W-1:0]]) begin
        outstanding = outstanding + ONE;
      end
    end
  end
`else
  // Every slot from fill up to wr is still waiting for memory.
  assign fill_eff    = fill_ptr;
  assign outstanding = wr_ptr - fill_ptr;
`endif

  // A response fills the oldest waiting slot unless it belongs to a fetch
  // killed by an earlier flush. A response in the flush cycle itself is
  // always dropped.
  assign fill_en = inst_sram_data_ok & (discard_cnt == ZERO) & ~flush;

  // In-flight responses left after a flush: those already being discarded,
  // plus every live fetch, plus a request the memory may take this cycle,
  // minus the one response arriving now. That response is either a discarded
  // one or the oldest live fetch.
  assign discard_flush = discard_cnt + outstanding
                       - {{PTR_W{1'b0}}, inst_sram_data_ok}
                       + {{PTR_W{1'b0}}, inst_sram_addr_ok & req_raw};

  // The head goes to decode only once its word is in. During a flush it is
  // hidden because it is about to be dropped.
  assign id_valid     = done[rd_idx] & (rd_ptr != wr_ptr) & ~flush;
  assign pop          = id_valid & id_ready;
  assign ic_to_id_bus = id_valid ? {ent_exc[rd_idx], ent_pc[rd_idx], ent_inst[rd_idx]}
                                 : 96'd0;

  // Pointer and discard-counter update. Flush takes priority over all else.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the values from before the edge, whatever the statement order.
    if (rst) begin
      wr_ptr      <= ZERO;
      fill_ptr    <= ZERO;
      rd_ptr      <= ZERO;
      discard_cnt <= ZERO;
    end else if (flush) begin
      wr_ptr      <= rd_ptr;
      fill_ptr    <= rd_ptr;
      discard_cnt <= discard_flush;
    end else begin
      if (alloc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      fill_ptr <= fill_en ? fill_eff + ONE : fill_eff;
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (inst_sram_data_ok && discard_cnt != ZERO) begin
        discard_cnt <= discard_cnt - ONE;
      end
    end
  end

  // Completion flags: cleared on allocation (set at once for an AdEL slot),
  // set when the word arrives, and wiped by a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= '0;
    end else if (flush) begin
      done <= '0;
    end else begin
      if (alloc) begin
        done[wr_idx] <= misaligned;
      end
      if (fill_en) begin
        done[fill_idx] <= 1'b1;
      end
    end
  end

  // Slot payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the payload arrays have no reset. Nothing reads a slot until its
    // done flag, which is reset, is set, so resetting the data would only add
    // reset fan-out to a plain register file.
    if (alloc) begin
      ent_exc[wr_idx] <= misaligned ? (exc_in | 32'h0000_4000) : exc_in;
      ent_pc[wr_idx]  <= pc_in;
      if (misaligned) begin
        ent_inst[wr_idx] <= 32'd0;
      end
    end
    if (fill_en) begin
      ent_inst[fill_idx] <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch.
// The reference model is a queue of fetches in program order, one entry per
// slot the stage should hold. Alongside it sits a memory model that returns
// words for every request it took, in order, including those made stale by a
// flush. Directed scenarios come first, then randomized traffic.

module tb_if_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [64:0] pc_to_ic_bus;
  logic        pc_ready;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [95:0] ic_to_id_bus;

  if_fetch #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .pc_to_ic_bus      (pc_to_ic_bus),
    .pc_ready          (pc_ready),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .id_valid          (id_valid),
    .id_ready          (id_ready),
    .ic_to_id_bus      (ic_to_id_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] exc;
    logic [31:0] inst;
    bit          done;
    int          id;
  } fetch_t;

  typedef struct {
    logic [31:0] data;
    bit          live;
    int          id;
    int          cyc;
  } mem_req_t;

  fetch_t      mq[$];
  mem_req_t    memq[$];
  int          next_id = 0;
  int          cyc = 0;

  // DUT observations from the latest step.
  logic        obs_req, obs_pc_ready, obs_valid;
  logic [31:0] obs_addr;
  logic [95:0] obs_bus;
  logic [95:0] last_pop_bus;
  int          pops = 0;
  logic [31:0] popped_pc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3c08_0000;
  endfunction

  task automatic drive_idle();
    pc_to_ic_bus      = 65'd0;
    flush             = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'd0;
    id_ready          = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    mq.delete();
    memq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the outputs against the model,
  // then advance the model to the state after the next rising edge.
  task automatic step(input bit ce, input logic [31:0] pc, input logic [31:0] exc,
                      input bit fl, input bit aok, input bit want_data, input bit rdy);
    bit       resp, mis, space, exp_req, exp_alloc, exp_valid;
    mem_req_t r;
    fetch_t   e;
    @(negedge clk);
    resp              = want_data && memq.size() > 0 && memq[0].cyc < cyc;
    pc_to_ic_bus      = {exc, ce, pc};
    flush             = fl;
    inst_sram_addr_ok = aok && (memq.size() < DEPTH);
    inst_sram_data_ok = resp;
    inst_sram_rdata   = resp ? memq[0].data : $urandom();
    id_ready          = rdy;
    #1;
`ifdef IF_ADEL_CHECK_EN
    mis = (pc[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    space     = mq.size() < DEPTH;
    exp_req   = ce && !fl && space && !mis;
    exp_alloc = ce && !fl && space && (mis || inst_sram_addr_ok);
    exp_valid = mq.size() > 0 && mq[0].done && !fl;

    obs_req      = inst_sram_req;
    obs_pc_ready = pc_ready;
    obs_valid    = id_valid;
    obs_addr     = inst_sram_addr;
    obs_bus      = ic_to_id_bus;
    if (id_valid && rdy) begin
      last_pop_bus = ic_to_id_bus;
      pops++;
      popped_pc.push_back(ic_to_id_bus[63:32]);
    end

    check("req", inst_sram_req, exp_req);
    if (exp_req) check("addr", inst_sram_addr, pc);
    check("pc_ready", pc_ready, exp_alloc);
    check("id_valid", id_valid, exp_valid);
    if (exp_valid) check("bus", ic_to_id_bus, {mq[0].exc, mq[0].pc, mq[0].inst});

    if (exp_valid && rdy) mq.delete(0);
    if (resp) begin
      r = memq.pop_front();
      if (r.live) begin
        foreach (mq[i]) begin
          if (mq[i].id == r.id) begin
            mq[i].done = 1'b1;
            mq[i].inst = r.data;
          end
        end
      end
    end
    if (exp_alloc) begin
      e.pc   = pc;
      e.exc  = mis ? (exc | 32'h0000_4000) : exc;
      e.inst = 32'd0;
      e.done = mis;
      e.id   = next_id;
      mq.push_back(e);
      if (!mis) memq.push_back('{data: mem_word(pc), live: 1'b1, id: next_id, cyc: cyc});
      next_id++;
    end
    // The memory may accept in a flush cycle even with req low; its word must still come back.
    if (fl && inst_sram_addr_ok && ce && space && !mis)
      memq.push_back('{data: 32'hbad0_0001, live: 1'b0, id: -1, cyc: cyc});
    if (fl) begin
      mq.delete();
      foreach (memq[i]) memq[i].live = 1'b0;
    end
    cyc++;
  endtask

  // Step until decode takes one word, or the budget runs out.
  task automatic wait_pop(input string tag, input int budget);
    int p0;
    p0 = pops;
    for (int i = 0; i < budget && pops == p0; i++) step(0, 32'd0, 32'd0, 0, 0, 1, 1);
    check(tag, pops - p0, 1);
  endtask

  initial begin
    int exp_pcs[5] = '{0, 4, 8, 12, 16};
    rst = 1'b1;
    drive_idle();
    pc_to_ic_bus = {32'd0, 1'b1, 32'hbfc0_0000};
    #3;
    check("rst_req", inst_sram_req, 1'b0);
    check("rst_pc_ready", pc_ready, 1'b0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_bus", ic_to_id_bus, 96'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic fetch with minimum latency.
    step(1, 32'hbfc0_0000, 32'd0, 0, 1, 0, 0);
    check("t1_addr", obs_addr, 32'hbfc0_0000);
    check("t1_pc_ready", obs_pc_ready, 1'b1);
    step(0, 32'd0, 32'd0, 0, 0, 1, 0);
    check("t1_not_yet", obs_valid, 1'b0);
    step(0, 32'd0, 32'd0, 0, 0, 0, 1);
    check("t1_valid", obs_valid, 1'b1);
    check("t1_bus", obs_bus, {32'd0, 32'hbfc0_0000, 32'h3c08_bfc0});

    // Fill to capacity while decode stalls, then pop one word.
    do_reset();
    popped_pc.delete();
    for (int i = 0; i < 5; i++) step(1, 32'(exp_pcs[i]), 32'd0, 0, 1, 1, 0);
    check("t2_full_req", obs_req, 1'b0);
    check("t2_full_pc_ready", obs_pc_ready, 1'b0);
    step(1, 32'h10, 32'd0, 0, 1, 1, 1);
    check("t2_pop_same_cycle_req", obs_req, 1'b0);
    step(1, 32'h10, 32'd0, 0, 1, 1, 0);
    check("t2_reopen_req", obs_req, 1'b1);
    for (int i = 0; i < 12; i++) step(0, 32'd0, 32'd0, 0, 0, 1, 1);
    check("t2_count", popped_pc.size(), 5);
    for (int k = 0; k < 5; k++)
      if (popped_pc.size() > k) check("t2_order", popped_pc[k], 32'(exp_pcs[k]));

    // Flush with two fetches in flight; their words must be dropped.
    do_reset();
    step(1, 32'h100, 32'd0, 0, 1, 0, 0);
    step(1, 32'h104, 32'd0, 0, 1, 0, 0);
    if (memq.size() == 2) begin
      memq[0].data = 32'hdead_beef;
      memq[1].data = 32'hcafe_f00d;
    end
    step(1, 32'hbfc0_0380, 32'd0, 1, 0, 0, 0);
    step(1, 32'hbfc0_0380, 32'd0, 0, 1, 1, 0);
    wait_pop("t3_delivered", 12);
    check("t3_pc", last_pop_bus[63:32], 32'hbfc0_0380);
    check("t3_inst", last_pop_bus[31:0], 32'h3f88_bfc0);

    // Flush in the same cycle as data_ok and addr_ok.
    do_reset();
    step(1, 32'h200, 32'd0, 0, 1, 0, 0);
    step(1, 32'h204, 32'd0, 0, 1, 0, 0);
    step(1, 32'hbfc0_0380, 32'd0, 1, 1, 1, 0);
    step(1, 32'hbfc0_0380, 32'd0, 0, 1, 0, 0);
    wait_pop("t4_delivered", 12);
    check("t4_pc", last_pop_bus[63:32], 32'hbfc0_0380);
    check("t4_inst", last_pop_bus[31:0], 32'h3f88_bfc0);

    // Asynchronous reset mid-transfer: two words in flight, one buffered.
    do_reset();
    step(1, 32'h300, 32'd0, 0, 1, 0, 0);
    step(1, 32'h304, 32'd0, 0, 1, 0, 0);
    step(1, 32'h308, 32'd0, 0, 1, 0, 0);
    step(0, 32'd0, 32'd0, 0, 0, 1, 0);
    @(negedge clk);
    drive_idle();
    pc_to_ic_bus = {32'd0, 1'b1, 32'h400};
    #1;
    check("t5_pre_valid", id_valid, 1'b1);
    check("t5_pre_req", inst_sram_req, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_req", inst_sram_req, 1'b0);
    check("t5_rst_pc_ready", pc_ready, 1'b0);
    check("t5_rst_valid", id_valid, 1'b0);
    check("t5_rst_bus", ic_to_id_bus, 96'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    memq.delete();
    step(1, 32'hbfc0_0000, 32'd0, 0, 1, 0, 0);
    wait_pop("t5_delivered", 8);
    check("t5_pc", last_pop_bus[63:32], 32'hbfc0_0000);
    check("t5_inst", last_pop_bus[31:0], 32'h3c08_bfc0);

`ifdef IF_ADEL_CHECK_EN
    // Misaligned pc: no memory request, complete at once with AdEL flagged.
    do_reset();
    step(1, 32'hbfc0_0002, 32'd0, 0, 1, 0, 0);
    check("t6_req", obs_req, 1'b0);
    check("t6_pc_ready", obs_pc_ready, 1'b1);
    step(0, 32'd0, 32'd0, 0, 0, 0, 1);
    check("t6_valid", obs_valid, 1'b1);
    check("t6_adel", obs_bus[78], 1'b1);
    check("t6_pc", obs_bus[63:32], 32'hbfc0_0002);
    check("t6_inst", obs_bus[31:0], 32'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      logic [31:0] rexc;
      bit          rfl;
      rpc  = $urandom();
      rexc = $urandom();
`ifdef IF_ADEL_CHECK_EN
      rpc[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
`endif
      rfl = ($urandom_range(0, 99) < 3);
      step($urandom_range(0, 99) < 80, rpc, rexc, rfl,
           !rfl && ($urandom_range(0, 99) < 60),
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 60);
    end
    for (int i = 0; i < 40; i++) step(0, 32'd0, 32'd0, 0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
